// File: rtl/keypad_scan_sequencer.sv
// -----------------------------------------------------------------------------
// keypad_scan_sequencer
//
// Scans a 3x3 matrix keypad one row at a time. The column levels are
// synchronized and debounced into a key code with a held/press strobe.
// While a key is being debounced or held, the active row stays frozen on it.
//
// Parameters:
//   SCAN_DIV      hwclk cycles each row is driven per scan step (3..2^20-1)
//   DEBOUNCE_CNT  consecutive matching samples to accept a press or release
//                 (2..2^20-1)
//
// Ports:
//   hwclk                      system clock (single clock domain)
//   rst                        synchronous active-high reset
//   keypad_r1..keypad_r3  out  row drives, active-low, exactly one low
//   keypad_c1..keypad_c3  in   asynchronous column inputs, low = pressed
//   button                out  last accepted key code 1..9 (0 only after reset)
//   bstate                out  high while a debounced key is held
//   key_valid             out  one-cycle pulse on each accepted press
//
// Optional feature macro: KEYPAD_GHOST_REJECT_EN
//   When defined, a capture with two or more columns low is treated as no key,
//   and an extra column going low during debounce aborts the press.
//   When undefined, priority c1 > c2 > c3 applies and extra columns are ignored.
// -----------------------------------------------------------------------------
module keypad_scan_sequencer #(
   parameter int SCAN_DIV     = 1200,
   parameter int DEBOUNCE_CNT = 120000
) (
   input  logic       hwclk,
   input  logic       rst,
   output logic       keypad_r1,
   output logic       keypad_r2,
   output logic       keypad_r3,
   input  logic       keypad_c1,
   input  logic       keypad_c2,
   input  logic       keypad_c3,
   output logic [3:0] button,
   output logic       bstate,
   output logic       key_valid
);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [19:0] ROW_LAST = 20'(SCAN_DIV - 1);
   localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CNT - 1);

   state_t      state;
   logic [2:0]  col_p0;    // raw columns, first synchronizer flop (bit0 = c1)
   logic [2:0]  col_p1;    // synchronized columns, active-low
   logic [2:0]  row_n;     // row drives r3..r1, active-low
   logic [19:0] row_cnt;
   logic [19:0] deb_cnt;
   logic [19:0] rel_cnt;
   logic [2:0]  lat_col;   // one-hot latched column, active-high
   logic [3:0]  lat_code;

   logic [2:0]  col_low;
   logic        lat_low;
   logic        other_low;
   logic        capture_ok;
   logic        deb_abort;
   logic        capture;

   // Highest-priority low column as a one-hot vector (c1 wins).
   function automatic logic [2:0] pick_col(input logic [2:0] low);
      if (low[0])      return 3'b001;
      else if (low[1]) return 3'b010;
      else if (low[2]) return 3'b100;
      else             return 3'b000;
   endfunction

   // True when two or more columns are low at once.
   function automatic logic multi_low(input logic [2:0] low);
      return (low[0] & low[1]) | (low[0] & low[2]) | (low[1] & low[2]);
   endfunction

   // Code 3*(r-1)+c from the active-low row vector and one-hot column.
   function automatic logic [3:0] key_code(input logic [2:0] rows,
                                           input logic [2:0] col);
      logic [3:0] base;
      logic [3:0] cnum;
      case (rows)
         3'b110:  base = 4'd0;
         3'b101:  base = 4'd3;
         default: base = 4'd6;
      endcase
      if (col[0])      cnum = 4'd1;
      else if (col[1]) cnum = 4'd2;
      else             cnum = 4'd3;
      return base + cnum;
   endfunction

   // r1 -> r2 -> r3 -> r1 on the active-low row vector.
   function automatic logic [2:0] next_row(input logic [2:0] rows);
      return {rows[1:0], rows[2]};
   endfunction

   assign col_low   = ~col_p1;
   assign lat_low   = |(col_low & lat_col);
   assign other_low = |(col_low & ~lat_col);

`ifdef KEYPAD_GHOST_REJECT_EN
   assign capture_ok = (|col_low) && !multi_low(col_low);
   assign deb_abort  = !lat_low || other_low;
`else
   assign capture_ok = |col_low;
   assign deb_abort  = !lat_low;
`endif

   assign capture = (state == SCAN) && (row_cnt == ROW_LAST) && capture_ok;

   assign keypad_r1 = row_n[0];
   assign keypad_r2 = row_n[1];
   assign keypad_r3 = row_n[2];

   // ---- stage p0/p1: two-flop column synchronizer ----
   always_ff @(posedge hwclk) begin
      col_p0 <= {keypad_c3, keypad_c2, keypad_c1};
      col_p1 <= col_p0;
   end

   // Key latch: row is current at the capture edge, so the code is final here.
   always_ff @(posedge hwclk) begin
      if (capture) begin
         lat_col  <= pick_col(col_low);
         lat_code <= key_code(row_n, pick_col(col_low));
      end
   end

   // ---- control FSM: scan / debounce / held ----
   always_ff @(posedge hwclk) begin
      if (rst) begin
         state     <= SCAN;
         row_n     <= 3'b110;
         row_cnt   <= '0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         button    <= 4'd0;
         bstate    <= 1'b0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (row_cnt == ROW_LAST) begin
                  row_cnt <= '0;
                  if (capture_ok) begin
                     state   <= DEBOUNCE;
                     deb_cnt <= 20'd1;
                  end else begin
                     row_n <= next_row(row_n);
                  end
               end else begin
                  row_cnt <= row_cnt + 20'd1;
               end
            end
            DEBOUNCE: begin
               if (deb_abort) begin
                  state   <= SCAN;
                  row_n   <= next_row(row_n);
                  row_cnt <= '0;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  // This edge is the DEBOUNCE_CNT-th matching sample.
                  state     <= HELD;
                  deb_cnt   <= '0;
                  rel_cnt   <= '0;
                  button    <= lat_code;
                  bstate    <= 1'b1;
                  key_valid <= 1'b1;
               end else begin
                  deb_cnt <= deb_cnt + 20'd1;
               end
            end
            HELD: begin
               // Only the latched column matters here; other columns are ignored.
               if (lat_low) begin
                  rel_cnt <= '0;
               end else if (rel_cnt == DEB_LAST) begin
                  state   <= SCAN;
                  bstate  <= 1'b0;
                  row_n   <= next_row(row_n);
                  row_cnt <= '0;
                  rel_cnt <= '0;
               end else begin
                  rel_cnt <= rel_cnt + 20'd1;
               end
            end
            default: begin
               state <= SCAN;
            end
         endcase
      end
   end

endmodule

// File: doc/keypad_scan_sequencer.md
# keypad_scan_sequencer

Scans the 3x3 matrix keypad and turns raw column levels into a debounced key code with a press/hold strobe. Sits between the keypad pins and the length checker, validity checker and lock controller, which all consume `button`/`bstate`. Drives rows one at a time, synchronizes and debounces columns, and holds the active row for the duration of a press.

## Interface
Parameters:
- `SCAN_DIV`, 1200: hwclk cycles each row is driven per scan step. Legal range is 3..2^20-1.
- `DEBOUNCE_CNT`, 120000: consecutive matching synchronized samples required to accept a press or a release. Legal range is 2..2^20-1.

Ports:
- `hwclk`  in  1  system clock. This is the single clock for the block.
- `rst`  in  1  reset. Synchronous, active-high.
- `keypad_r1`/`keypad_r2`/`keypad_r3`  out  1 each  row drives, active-low. Exactly one row is low at any time.
- `keypad_c1`/`keypad_c2`/`keypad_c3`  in  1 each  column inputs. They are asynchronous, externally pulled up, and low means pressed.
- `button`  out  4  key code 1..9, where row r and column c give code 3*(r-1)+c. The value 0 appears only after reset.
- `bstate`  out  1  high while a debounced key is held.
- `key_valid`  out  1  one-cycle pulse on each accepted press.

## Operation
- The columns pass through a 2-flop synchronizer. All decisions below use only the synchronized values.
- Reset values:
  - rows = r1 low (r3..r1 = 110)
  - `button`=0, `bstate`=0, `key_valid`=0
  - state SCAN
  - all counters 0
- **SCAN**
  - `row_cnt` counts 0..SCAN_DIV-1.
  - When `row_cnt`==SCAN_DIV-1, the columns are sampled.
  - If no column is low: advance to the next row (r1→r2→r3→r1) and clear `row_cnt`.
  - If a column is low: latch row/column, set `deb_cnt`=1, go to DEBOUNCE. The row is held.
- **DEBOUNCE**
  - Each edge where the latched column is still low increments `deb_cnt`.
  - Any high sample returns the block to SCAN: advance row, clear `row_cnt`. `bstate` and `key_valid` are not touched.
  - On the edge where `deb_cnt` reaches DEBOUNCE_CNT: go to HELD and assert `button`=code, `bstate`=1, `key_valid`=1.
- **HELD**
  - The row stays held and `key_valid` returns to 0.
  - `rel_cnt` counts consecutive high samples of the latched column. A low sample clears it.
  - On the edge where `rel_cnt` reaches DEBOUNCE_CNT: `bstate`=0, go to SCAN, advance row, clear `row_cnt`.
  - `button` keeps its last code until the next accepted press.
- Multiple columns low at capture: priority c1 > c2 > c3. After capture, only the latched column is watched.
- Only one key is tracked at a time. Other keys are ignored until return to SCAN.
- `rst` during any state forces the reset values on the next edge. An in-flight press is discarded and no `key_valid` is emitted.

## Timing
- All outputs are registered and change only on the rising edge of `hwclk`.
- Column-to-decision latency is 2 cycles (synchronizer). Sampling only at the last dwell cycle guarantees the synchronized columns reflect the current row.
- Press acceptance: `bstate`/`key_valid` rise DEBOUNCE_CNT-1 edges after the capture edge.
- Release: `bstate` falls on the DEBOUNCE_CNT-th consecutive high synchronized sample.
- `bstate` minimum low time equals one full row dwell (SCAN_DIV cycles) before any re-capture.
- `key_valid` is high for exactly 1 cycle per accepted press, coincident with the `bstate` rising edge.

## Configuration
- Macro `KEYPAD_GHOST_REJECT_EN`.
- Defined:
  - A capture sample with two or more columns low is treated as no key: the row advances and nothing is latched.
  - In DEBOUNCE, any additional column going low aborts to SCAN.
  - In HELD, additional columns are ignored.
- Undefined: priority c1 > c2 > c3 applies, and extra columns are ignored in every state.

## Test plan
Bench overrides: SCAN_DIV=4, DEBOUNCE_CNT=8.
- **Reset and idle scan.** Assert `rst`, release it, keep all columns high → rows 110 for 4 cycles, then 101, then 011, then 110 repeating. `button`=0, `bstate`=0, `key_valid` never high.
- **Clean press of key 5.** Drive c2 low whenever r2 is low, hold for 60 cycles, then release → `button`=5, `bstate`=1, a single `key_valid` pulse, rows frozen at 101 while held. `bstate` falls 8 synchronized high samples after release, `button` stays 5, and scanning resumes at r3.
- **Bounce reject.** c1 low for 3 cycles during the r1 capture, then high → `bstate` stays 0, no `key_valid`, and the next driven row is r2.
- **Two keys on row 3 (c1 and c3 low).** Macro undefined → `button`=7 with one `key_valid`. Macro defined → no capture, and scanning continues unchanged.
- **Release glitch.** In HELD, c2 goes high for 5 cycles then low again → `bstate` stays 1 and no second `key_valid`. A later 8+ cycle release clears `bstate`.
- **Reset mid-operation.** Assert `rst` in DEBOUNCE and again in HELD → on the next edge `bstate`=0, `button`=0, rows=110, and `key_valid` is not pulsed.
